// File: rtl/jtdd_slot_arb.sv
// Four-slot SDRAM read arbiter with a one-word cache per slot (char, scroll, ADPCM, MCU).
// Define JTDD_SLOT0_PRIO_EN to give slot 0 absolute priority over the round-robin slots 1-3.
module jtdd_slot_arb #(
  parameter int          SLOT0_AW     = 15,
  parameter int          SLOT1_AW     = 17,
  parameter int          SLOT2_AW     = 16,
  parameter int          SLOT3_AW     = 16,
  parameter logic [21:0] SLOT0_OFFSET = 22'h2_8000,
  parameter logic [21:0] SLOT1_OFFSET = 22'h6_0000,
  parameter logic [21:0] SLOT2_OFFSET = 22'h1_8000,
  parameter logic [21:0] SLOT3_OFFSET = 22'h2_0000,
  parameter logic [1:0]  RR_START     = 2'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic                slot0_cs,
  input  logic                slot1_cs,
  input  logic                slot2_cs,
  input  logic                slot3_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  input  logic [SLOT2_AW-1:0] slot2_addr,
  input  logic [SLOT3_AW-1:0] slot3_addr,
  output logic [15:0]         slot0_dout,
  output logic [15:0]         slot1_dout,
  output logic [15:0]         slot2_dout,
  output logic [15:0]         slot3_dout,
  output logic                slot0_ok,
  output logic                slot1_ok,
  output logic                slot2_ok,
  output logic                slot3_ok,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [15:0]         data_read,
  output logic [21:0]         sdram_addr
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  localparam logic [3:0][21:0] OFFSET = {SLOT3_OFFSET, SLOT2_OFFSET, SLOT1_OFFSET, SLOT0_OFFSET};

  state_t      state, state_nxt;
  logic [1:0]  gnt, gsel, rr;
  logic        any_pend, fill, clr;
  logic [21:0] cand;
  logic [21:0] addr_ext [4];
  logic [21:0] tag      [4];
  logic [15:0] data     [4];
  logic [3:0]  valid, cs, ok, pend, pend_rr;

  // Tags are kept 22 bits wide so every slot compares against a zero-extended address.
  always_comb begin
    addr_ext[0] = 22'(slot0_addr);
    addr_ext[1] = 22'(slot1_addr);
    addr_ext[2] = 22'(slot2_addr);
    addr_ext[3] = 22'(slot3_addr);
  end

  assign cs  = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign clr = rst | downloading;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ok[i]   = cs[i] & valid[i] & (addr_ext[i] == tag[i]);
      pend[i] = cs[i] & ~ok[i];
    end
  end

  assign {slot3_ok, slot2_ok, slot1_ok, slot0_ok} = ok;
  assign slot0_dout = data[0];
  assign slot1_dout = data[1];
  assign slot2_dout = data[2];
  assign slot3_dout = data[3];

  // First pending slot at or after rr; descending scan so the closest one is assigned last.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every variable written here gets a default first, otherwise paths that skip an assignment infer a latch.
    gsel     = rr;
    any_pend = 1'b0;
    idx      = 2'd0;
    pend_rr  = pend;
`ifdef JTDD_SLOT0_PRIO_EN
    pend_rr[0] = 1'b0;
`endif
    for (int k = 3; k >= 0; k--) begin
      idx = rr + 2'(k);
      if (pend_rr[idx]) begin
        gsel     = idx;
        any_pend = 1'b1;
      end
    end
`ifdef JTDD_SLOT0_PRIO_EN
    if (pend[0]) begin
      gsel     = 2'd0;
      any_pend = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any_pend)  state_nxt = WAIT_ACK;
      WAIT_ACK: if (sdram_ack) state_nxt = data_rdy ? IDLE : WAIT_RDY;
      WAIT_RDY: if (data_rdy)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // An ack and data_rdy together in WAIT_ACK complete the transfer in one step.
  assign fill = data_rdy & ((state == WAIT_RDY) | ((state == WAIT_ACK) & sdram_ack));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      gnt        <= 2'd0;
      cand       <= '0;
      rr         <= RR_START;
      valid      <= '0;
      // NOTE: the cache words are reset on purpose because dout must read zero after reset.
      for (int i = 0; i < 4; i++) begin
        data[i] <= '0;
        tag[i]  <= '0;
      end
    end else begin
      if (state == IDLE && any_pend) begin
        gnt        <= gsel;
        cand       <= addr_ext[gsel];
        sdram_addr <= OFFSET[gsel] + addr_ext[gsel];
        sdram_req  <= 1'b1;
      end
      if (state == WAIT_ACK && sdram_ack) sdram_req <= 1'b0;
      if (fill) begin
        data[gnt]  <= data_read;
        tag[gnt]   <= cand;
        valid[gnt] <= 1'b1;
`ifdef JTDD_SLOT0_PRIO_EN
        if (gnt != 2'd0) rr <= gnt + 2'd1;
`else
        rr <= gnt + 2'd1;
`endif
      end
    end
  end

endmodule

// File: doc/jtdd_slot_arb.md
Name: jtdd_slot_arb

Overview:
- Four-slot SDRAM read arbiter for the Double Dragon core.
- Serves the char, scroll, ADPCM and MCU ROM requesters through one SDRAM read port (req/ack/data_rdy).
- Each slot holds a one-word cache so that repeated addresses complete without any SDRAM traffic.
- Sits between the game-level ROM request wires and the jtframe SDRAM controller.

Parameters:
- SLOTn_AW, n=0..3, defaults 15/17/16/16: word-address width of slot n.
- SLOTn_OFFSET, n=0..3, defaults 22'h2_8000/22'h6_0000/22'h1_8000/22'h2_0000: word offset added to slot n addresses.
- RR_START, default 0: slot that holds top priority after reset.

Ports:
- clk  in  1: system clock.
- rst  in  1: synchronous, active-high reset.
- downloading  in  1: ROM download in progress.
- slotN_cs  in  1: slot N request enable (N=0..3).
- slotN_addr  in  SLOTN_AW: slot N word address.
- slotN_dout  out  16: cached word for slot N.
- slotN_ok  out  1: slot N data valid for current slotN_addr.
- sdram_req  out  1: read request.
- sdram_ack  in  1: request accepted by the controller.
- data_rdy  in  1: data_read valid, single-cycle pulse.
- data_read  in  16: SDRAM read data.
- sdram_addr  out  22: SDRAM word address.

Behaviour:
Clock, reset and reset values
- Single clock clk. Reset rst is synchronous and active-high.
- Reset (and any cycle with downloading=1):
  - FSM to IDLE; sdram_req=0; sdram_addr=0.
  - All cache valid bits cleared; all slotN_dout=0.
  - Round-robin pointer = RR_START.
- rst asserted mid-transfer aborts that transfer. A data_rdy arriving afterwards is ignored.

Hit detection
- slotN_ok = slotN_cs & validN & (slotN_addr == tagN). This is combinational: ok drops in the same cycle the address changes.
- slotN_dout = dataN (registered).
- Slot N is pending when slotN_cs=1 and slotN_ok=0.

FSM states
- IDLE:
  - If any slot is pending, grant the first pending slot at or after the RR pointer, cyclic 0..3.
  - Latch grant index g and tag candidate = slotg_addr.
  - sdram_addr <= SLOTg_OFFSET + zero-extended slotg_addr, modulo 2^22 (wrap, no saturation).
  - sdram_req <= 1; go to WAIT_ACK.
  - Request appears one clock after the miss is visible.
- WAIT_ACK: hold sdram_req and sdram_addr stable. On sdram_ack: sdram_req <= 0; go to WAIT_RDY.
- WAIT_RDY: on data_rdy:
  - dataG <= data_read; tagG <= latched address; validG <= 1.
  - RR pointer <= g+1 (mod 4); go to IDLE.
  - slotg_ok rises the cycle after data_rdy, provided the address is unchanged.

Boundary cases
- ack and data_rdy in the same cycle while in WAIT_ACK: treat as ack then data; complete directly to IDLE.
- data_rdy in IDLE or WAIT_ACK without a prior ack: ignored.
- Slot address changes during a fetch: the fetch still completes and fills the cache with the old address. ok stays low, and the slot re-requests from IDLE.
- slotN_cs dropped mid-fetch: the fetch completes and fills the cache. No ok is shown while cs=0.
- Hit slots never generate requests. Only one transfer is outstanding at any time.
- Worst-case wait for any slot: 3 other fetches.

Optional Feature:
- Macro: JTDD_SLOT0_PRIO_EN.
- Defined:
  - Slot 0 (char) wins arbitration whenever it is pending.
  - Slots 1-3 share the round-robin order.
  - The RR pointer is not advanced by slot-0 grants.
- Undefined: pure 4-way round-robin as described in Behaviour.

Test Plan:
- Reset, then slot0_cs=1, addr=15'h0010. Controller acks 2 cycles after req and gives data_rdy 3 cycles later with 16'hBEEF. Expect:
  - sdram_addr=22'h2_8010;
  - slot0_ok=1 and slot0_dout=16'hBEEF the cycle after data_rdy;
  - exactly one req pulse.
- Repeat slot0 addr 15'h0010 for 20 cycles. Expect slot0_ok held at 1 and sdram_req stays 0.
- All four slots miss simultaneously with RR pointer=0. Expect grant order 0,1,2,3. Then slot1 and slot2 miss again: expect order 1 then 2, following the pointer after slot 3.
- slot1 addr changes from 17'h00100 to 17'h00101 between ack and data_rdy. Expect:
  - slot1_ok stays 0;
  - a second req with sdram_addr=22'h6_0101;
  - ok=1 after that fill.
- Assert rst in WAIT_RDY, then deliver data_rdy. Expect no cache fill, all ok=0, and sdram_req=0 after the reset edge. downloading=1 gives the same result.
- With JTDD_SLOT0_PRIO_EN defined, keep slot0 and slot3 continuously missing (new address after each fill). Expect slot0 granted in every IDLE where it is pending. Without the macro, grants alternate 0,3,0,3.
